// File: rtl/fix2fp_sample_feeder.sv
// Q1.15 fixed-point to IEEE-754 single converter feeding the DFT real-input
// channel; two-stage pipeline with frame index tracking.
module fix2fp_sample_feeder #(
    parameter int N_POINTS = 16,
    parameter int IDX_W    = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_sample_vld,
    output logic             i_sample_busy,
    input  logic [15:0]      i_sample_data,
    output logic             o_real_vld,
    input  logic             o_real_busy,
    output logic [22:0]      o_real_data_man,
    output logic [7:0]       o_real_data_exp,
    output logic             o_real_data_sign,
    output logic [IDX_W-1:0] o_sample_idx,
    output logic             o_frame_done
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(N_POINTS - 1);

    logic        stall;
    logic        s1_load;
    logic        out_xfer;
    logic        s1_vld;
    logic        s1_sign;
    logic        s1_zero;
    logic [16:0] s1_mag;
    logic [16:0] ext;
    logic [16:0] mag_in;
    logic [4:0]  lead;
    logic [22:0] man_n;
    logic [7:0]  exp_n;

    assign stall         = o_real_vld & o_real_busy;
    assign s1_load       = !s1_vld | !stall;
    assign out_xfer      = o_real_vld & !o_real_busy;
    assign i_sample_busy = s1_vld & stall;

    // sign-extend before negating so -32768 yields magnitude 32768
    assign ext    = {i_sample_data[15], i_sample_data};
    assign mag_in = i_sample_data[15] ? (~ext + 17'd1) : ext;

    always_comb begin
        lead = '0;
        for (int i = 0; i < 17; i++) begin
            if (s1_mag[i]) lead = 5'(i);
        end
    end

    // bits below the leading one, left-aligned to man[22]
    always_comb begin
        man_n = '0;
        for (int i = 0; i < 23; i++) begin
            if (i + int'(lead) >= 23) man_n[i] = s1_mag[i + int'(lead) - 23];
        end
    end

    assign exp_n = 8'd112 + {3'b000, lead};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_vld  <= 1'b0;
            s1_sign <= 1'b0;
            s1_zero <= 1'b1;
            s1_mag  <= '0;
        end else if (s1_load) begin
            s1_vld <= i_sample_vld;
            if (i_sample_vld) begin
                s1_sign <= i_sample_data[15];
                s1_zero <= (i_sample_data == 16'h0000);
                s1_mag  <= mag_in;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_real_vld       <= 1'b0;
            o_real_data_man  <= '0;
            o_real_data_exp  <= '0;
            o_real_data_sign <= 1'b0;
        end else if (!stall) begin
            o_real_vld <= s1_vld;
            if (s1_vld) begin
                o_real_data_sign <= s1_sign & !s1_zero;
                o_real_data_exp  <= s1_zero ? 8'd0 : exp_n;
                o_real_data_man  <= s1_zero ? 23'd0 : man_n;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_sample_idx <= '0;
            o_frame_done <= 1'b0;
        end else begin
            o_frame_done <= out_xfer && (o_sample_idx == LAST);
            if (out_xfer) begin
                if (o_sample_idx == LAST) o_sample_idx <= '0;
                else o_sample_idx <= o_sample_idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fix2fp_sample_feeder.sv
// Bench for fix2fp_sample_feeder: scoreboard of converted samples plus
// per-scenario directed checks.
module tb_fix2fp_sample_feeder;

    localparam int N = 16;
    localparam int W = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          s_vld = 1'b0;
    logic          s_busy;
    logic [15:0]   s_data = '0;
    logic          r_vld;
    logic          r_busy = 1'b0;
    logic [22:0]   r_man;
    logic [7:0]    r_exp;
    logic          r_sign;
    logic [W-1:0]  r_idx;
    logic          r_fd;

    int checks = 0;
    int passed = 0;
    logic [31:0] q[$];
    int exp_idx = 0;
    bit exp_fd = 0;
    bit was_stall = 0;
    logic [31:0] held;
    logic [W-1:0] held_idx;
    int fd_seen = 0;

    fix2fp_sample_feeder #(.N_POINTS(N), .IDX_W(W)) dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_sample_vld(s_vld),
        .i_sample_busy(s_busy),
        .i_sample_data(s_data),
        .o_real_vld(r_vld),
        .o_real_busy(r_busy),
        .o_real_data_man(r_man),
        .o_real_data_exp(r_exp),
        .o_real_data_sign(r_sign),
        .o_sample_idx(r_idx),
        .o_frame_done(r_fd)
    );

    always #5 clk = ~clk;

    // reference: normalize by doubling until bit 15 is set
    function automatic logic [31:0] ref_conv(input logic [15:0] d);
        int v;
        int m;
        int s;
        if (d == 16'h0000) return 32'h0;
        v = int'($signed(d));
        m = (v < 0) ? -v : v;
        s = 0;
        while (m < 32768) begin
            m = m * 2;
            s++;
        end
        return {d[15], 8'(127 - s), m[14:0], 8'h00};
    endfunction

    function automatic logic [15:0] pick();
        logic [15:0] sp[6];
        sp = '{16'h0000, 16'h8000, 16'h7FFF, 16'h0001, 16'hFFFF, 16'h4000};
        if ($urandom_range(7) == 0) return sp[$urandom_range(5)];
        return 16'($urandom);
    endfunction

    always @(negedge clk) begin
        logic [31:0] got;
        logic [31:0] want;
        bit exp_busy;
        if (rst) begin
            q.delete();
            exp_idx = 0;
            exp_fd = 0;
            was_stall = 0;
        end else begin
            got = {r_sign, r_exp, r_man};
            if (r_fd === 1'b1) fd_seen++;
            checks++;
            if (r_fd !== exp_fd)
                $display("FAIL frame_done: got %b want %b", r_fd, exp_fd);
            else passed++;
            exp_fd = 0;
            exp_busy = r_vld && r_busy && (q.size() == 2);
            checks++;
            if (s_busy !== exp_busy)
                $display("FAIL sample_busy: got %b want %b", s_busy, exp_busy);
            else passed++;
            if (was_stall) begin
                checks++;
                if (r_vld !== 1'b1 || got !== held || r_idx !== held_idx)
                    $display("FAIL hold: got %b/%h/%0d want 1/%h/%0d",
                             r_vld, got, r_idx, held, held_idx);
                else passed++;
            end
            if (r_vld === 1'b1 && r_busy === 1'b0) begin
                checks++;
                if (q.size() == 0) begin
                    $display("FAIL unexpected_out: got %h want none", got);
                end else begin
                    want = q.pop_front();
                    if (got !== want || r_idx !== W'(exp_idx))
                        $display("FAIL out: got %h idx %0d want %h idx %0d",
                                 got, r_idx, want, exp_idx);
                    else passed++;
                end
                exp_fd = (exp_idx == N - 1);
                exp_idx = (exp_idx == N - 1) ? 0 : exp_idx + 1;
            end
            if (s_vld === 1'b1 && s_busy === 1'b0) q.push_back(ref_conv(s_data));
            was_stall = r_vld && r_busy;
            held = got;
            held_idx = r_idx;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        s_vld = 1'b0;
        r_busy = 1'b0;
        cyc();
        rst = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        s_vld = 1'b0;
        r_busy = 1'b0;
        while (n < 30 && !(q.size() == 0 && r_vld === 1'b0)) begin
            cyc();
            n++;
        end
        checks++;
        if (q.size() != 0 || r_vld !== 1'b0)
            $display("FAIL drain: got %0d pending want 0", q.size());
        else passed++;
    endtask

    task automatic stream(input int n, input int vpct, input int bpct,
                          output int cycles);
        int sent = 0;
        logic [15:0] d = pick();
        cycles = 0;
        while (sent < n && cycles < 20000) begin
            s_vld = ($urandom_range(99) < vpct);
            s_data = d;
            r_busy = ($urandom_range(99) < bpct);
            #1;
            if (s_vld && !s_busy) begin
                sent++;
                d = pick();
            end
            cyc();
            cycles++;
        end
        s_vld = 1'b0;
        checks++;
        if (sent != n) $display("FAIL stream_timeout: got %0d want %0d", sent, n);
        else passed++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) cyc();
        checks++;
        if (r_vld !== 1'b0 || r_idx !== '0 || r_fd !== 1'b0 || s_busy !== 1'b0)
            $display("FAIL reset_ctl: got %b %0d %b %b want 0 0 0 0",
                     r_vld, r_idx, r_fd, s_busy);
        else passed++;
        checks++;
        if ({r_sign, r_exp, r_man} !== 32'h0)
            $display("FAIL reset_data: got %h want 0", {r_sign, r_exp, r_man});
        else passed++;
        rst = 1'b0;
    endtask

    task automatic test_convert();
        logic [15:0] cd[7];
        logic [31:0] ce[7];
        int c;
        cd = '{16'h4000, 16'h6000, 16'h0001, 16'h8000,
               16'hC000, 16'h0000, 16'h7FFF};
        ce = '{{1'b0, 8'd126, 23'h000000}, {1'b0, 8'd126, 23'h400000},
               {1'b0, 8'd112, 23'h000000}, {1'b1, 8'd127, 23'h000000},
               {1'b1, 8'd126, 23'h000000}, {1'b0, 8'd0, 23'h000000},
               {1'b0, 8'd126, 23'h7FFE00}};
        for (int i = 0; i < 7; i++) begin
            s_vld = 1'b1;
            s_data = cd[i];
            cyc();
            s_vld = 1'b0;
            checks++;
            if (r_vld !== 1'b0)
                $display("FAIL latency_early %0d: got %b want 0", i, r_vld);
            else passed++;
            cyc();
            checks++;
            if (r_vld !== 1'b1 || {r_sign, r_exp, r_man} !== ce[i])
                $display("FAIL convert %0d: got %b/%h want 1/%h",
                         i, r_vld, {r_sign, r_exp, r_man}, ce[i]);
            else passed++;
        end
        c = 0;
        for (int i = 0; i < 7; i++) begin
            s_vld = 1'b1;
            s_data = cd[i];
            cyc();
        end
        drain();
    endtask

    task automatic test_stall();
        int sent = 0;
        int c = 0;
        logic [15:0] d = 16'h1234;
        while (sent < 12 && c < 100) begin
            s_vld = 1'b1;
            s_data = d;
            r_busy = (c >= 4 && c <= 6);
            #1;
            if (c >= 4 && c <= 7) begin
                checks++;
                if (s_busy !== (c != 7))
                    $display("FAIL stall_busy c%0d: got %b want %b",
                             c, s_busy, c != 7);
                else passed++;
            end
            if (!s_busy) begin
                sent++;
                d = d * 16'd37 + 16'd1;
            end
            cyc();
            c++;
        end
        drain();
    endtask

    task automatic test_back_to_back();
        int cycles;
        apply_reset();
        fd_seen = 0;
        stream(20, 100, 0, cycles);
        checks++;
        if (cycles != 20) $display("FAIL b2b_rate: got %0d want 20", cycles);
        else passed++;
        drain();
        checks++;
        if (fd_seen != 1 || r_idx !== 4'd4)
            $display("FAIL b2b_frame: got %0d/%0d want 1/4", fd_seen, r_idx);
        else passed++;
    endtask

    task automatic test_reset_midframe();
        int c = 0;
        int cycles;
        apply_reset();
        while (!(exp_idx == 7 && q.size() == 2) && c < 50) begin
            s_vld = 1'b1;
            s_data = pick();
            cyc();
            c++;
        end
        rst = 1'b1;
        s_vld = 1'b0;
        cyc();
        rst = 1'b0;
        checks++;
        if (c >= 50 || r_vld !== 1'b0 || r_idx !== '0 || s_busy !== 1'b0)
            $display("FAIL midframe_reset: got %b/%0d/%0d want 0/0/<50",
                     r_vld, r_idx, c);
        else passed++;
        stream(3, 100, 0, cycles);
        drain();
    endtask

    task automatic test_random();
        int cycles;
        stream(1000, 70, 40, cycles);
        drain();
    endtask

    initial begin
        test_reset();
        test_convert();
        test_stall();
        test_back_to_back();
        test_reset_midframe();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/fix2fp_sample_feeder.md
Name: fix2fp_sample_feeder

Overview:
- Upstream neighbour of the DFT compute stage.
- Accepts signed Q1.15 fixed-point time-domain samples over a vld/busy stream. Converts each sample exactly to IEEE-754 single precision, split into sign/exp/man fields, and drives them into the DFT real-input channel.
- Counts samples per frame and flags the last sample and frame completion, so the DFT sees frames of exactly N_POINTS samples.

Parameters:
- N_POINTS, 16, samples per DFT frame (>=2).
- IDX_W, 4, width of sample-index counter; must satisfy 2^IDX_W >= N_POINTS.

Ports:
- i_clk  input  1  clock, all logic on rising edge.
- i_rst  input  1  synchronous reset, active-high.
- i_sample_vld  input  1  upstream sample valid.
- i_sample_busy  output  1  block cannot accept a sample this cycle.
- i_sample_data  input  16  signed Q1.15 sample (value = data/32768).
- o_real_vld  output  1  float sample valid to DFT.
- o_real_busy  input  1  DFT cannot accept.
- o_real_data_man  output  23  mantissa field.
- o_real_data_exp  output  8  biased exponent field.
- o_real_data_sign  output  1  sign field.
- o_sample_idx  output  IDX_W  index within frame of the sample currently on o_real.
- o_frame_done  output  1  one-cycle pulse after the N_POINTS-th output transfer.

Behaviour:
- Transfer rule, both channels: a transfer occurs at a rising edge where vld=1 and busy=0.
- Reset: synchronous, active-high, with priority over everything. On reset:
  - o_real_vld=0, man/exp/sign=0, o_sample_idx=0, o_frame_done=0, i_sample_busy=0.
  - Both internal stage valids are cleared.
  - Reset mid-frame discards in-flight samples; the next frame restarts at index 0.
- Pipeline: two stages.
  - S1 registers sign, 17-bit magnitude |x| and a zero flag.
  - S2 performs the leading-one detect and normalize into the output registers.
  - Latency from input transfer to o_real_vld=1 is 2 cycles when not stalled. Throughput is 1 sample/cycle.
- Stall:
  - stall = o_real_vld & o_real_busy.
  - S2 holds while stall=1.
  - S1 loads when (!s1_vld | !stall); bubbles collapse.
  - i_sample_busy = s1_vld & stall (combinational).
  - Output fields are held stable while o_real_vld=1 and not transferred.
- Conversion, exact with no rounding:
  - x=0: sign=0, exp=0, man=0.
  - Otherwise sign=x[15] and m=|x|; -32768 gives m=32768.
  - p = position of the leading one of m (0..15).
  - exp = 112+p.
  - man = bits of m below p, left-aligned to man[22]; remaining bits are 0.
- Frame counter:
  - o_sample_idx increments on each output transfer.
  - It wraps from N_POINTS-1 to 0 on that transfer. o_frame_done pulses high for exactly the following cycle.
  - The counter is not advanced by input transfers or by stalls.
- Simultaneous events:
  - An output transfer and an S2 reload in the same cycle give back-to-back o_real_vld=1 with no bubble.
  - An input transfer while the output is stalled and S1 is empty is accepted into S1.

Test Plan:
- Reset, then samples 0x4000, 0x6000, 0x0001 with o_real_busy=0 → 2 cycles after each input, out (s,e,m) = (0,126,0x000000), (0,126,0x400000), (0,112,0x000000) on consecutive cycles.
- Samples 0x8000, 0xC000, 0x0000, 0x7FFF → (1,127,0), (1,126,0), (0,0,0), (0,126,0x7FFE00).
- Continuous input, o_real_busy high for 3 cycles mid-stream → output held stable; i_sample_busy=1 once S1 is full; no sample lost or duplicated; order preserved.
- Stream 20 samples with N_POINTS=16 → o_sample_idx goes 0..15,0..3; o_frame_done high exactly the cycle after the 16th output transfer.
- Assert i_rst for 1 cycle with 2 samples in flight at idx=7 → next cycle o_real_vld=0, o_sample_idx=0; the next accepted sample emerges with idx 0.
- Random vld/busy toggling for 1000 samples → outputs match a bit-exact reference model; no transfer while busy=1.
